// File: rtl/mem_line_bridge_if.sv
// mem_line_bridge_if -- bundles the CPU word port and the physical-memory
// line port of mem_line_bridge.
//
// Signals:
//   mem_read, mem_write      CPU word read / write request, held until mem_resp
//   mem_byte_enable[1:0]     bit0 = byte [7:0], bit1 = byte [15:8]
//   mem_address[15:0]        CPU byte address (bit 0 ignored)
//   mem_wdata[15:0]          CPU write data
//   mem_resp                 one-cycle completion strobe to the CPU
//   mem_rdata[15:0]          registered read word
//   pmem_read, pmem_write    line request to physical memory
//   pmem_address[15:0]       line-aligned address
//   pmem_wdata[127:0]        line write data, word k at [16k+15:16k]
//   pmem_rdata[127:0]        line read data, valid with pmem_resp
//   pmem_resp                physical transaction complete
//
// Modports:
//   slave  -- the bridge itself
//   master -- the CPU and physical memory that surround it
interface mem_line_bridge_if;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic         mem_resp;
    logic [15:0]  mem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/mem_line_bridge.sv
// mem_line_bridge -- adapts 16-bit CPU word accesses to 128-bit (8 x 16)
// physical-memory line transactions through a single-line buffer.
//
// Ports:
//   clk  -- sole clock, rising edge
//   rst  -- asynchronous, active-high reset
//   bus  -- mem_line_bridge_if.slave (CPU word port + physical line port)
//
// Behaviour: a read hit completes with mem_resp one cycle after the request;
// a miss fetches the whole line first. Writes merge the enabled bytes into
// the buffered line and write the full line back to physical memory.
//
// Configuration macro MEM_LINE_BUF_EN:
//   defined   -- the buffer's valid bit and tag produce hits.
//   undefined -- hit is forced to 0: every read fetches, every write
//                fetches then writes. Ports are identical in both builds.
module mem_line_bridge (
    input  logic              clk,
    input  logic              rst,
    mem_line_bridge_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    state_t       state;
    state_t       next_state;
    logic [127:0] line;
    logic [15:0]  rdata_q;
    logic         hit;
    logic         request;
    logic         is_write;
    logic [2:0]   word_idx;
    logic         unused_addr_bit;

    // Read and write together is treated as a write.
    assign request         = bus.mem_read | bus.mem_write;
    assign is_write        = bus.mem_write;
    assign word_idx        = bus.mem_address[3:1];
    assign unused_addr_bit = bus.mem_address[0];

    // Replace only the enabled bytes of the selected word.
    function automatic logic [127:0] merge_line(
        input logic [127:0] base,
        input logic [2:0]   idx,
        input logic [15:0]  wdata,
        input logic [1:0]   be
    );
        logic [127:0] result;
        result = base;
        if (be[0]) result[{idx, 4'd0} +: 8] = wdata[7:0];
        if (be[1]) result[{idx, 4'd8} +: 8] = wdata[15:8];
        return result;
    endfunction

    function automatic logic [15:0] select_word(
        input logic [127:0] l,
        input logic [2:0]   idx
    );
        return l[{idx, 4'd0} +: 16];
    endfunction

`ifdef MEM_LINE_BUF_EN
    logic        valid;
    logic [11:0] tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= 12'h000;
        end else if (state == FETCH && bus.pmem_resp) begin
            valid <= 1'b1;
            tag   <= bus.mem_address[15:4];
        end
    end

    assign hit = valid && (tag == bus.mem_address[15:4]);
`else
    assign hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state <= next_state;
        end
    end

    // Next-state logic. pmem_resp is only looked at in FETCH and WRITE.
    always_comb begin
        // NOTE: default assignment first keeps this block free of latches.
        next_state = state;
        case (state)
            IDLE: begin
                if (request) begin
                    if (!hit)          next_state = FETCH;
                    else if (is_write) next_state = WRITE;
                    else               next_state = DONE;
                end
            end
            FETCH: begin
                if (bus.pmem_resp) next_state = is_write ? WRITE : DONE;
            end
            WRITE: begin
                if (bus.pmem_resp) next_state = DONE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode: every strobe is a pure function of the state, so reset
    // clears them at once.
    always_comb begin
        bus.mem_resp   = (state == DONE);
        bus.pmem_read  = (state == FETCH);
        bus.pmem_write = (state == WRITE);
    end

    // The CPU holds its address while busy, so the line address is stable
    // throughout a physical transaction.
    assign bus.pmem_address = {bus.mem_address[15:4], 4'h0};
    assign bus.pmem_wdata   = line;
    assign bus.mem_rdata    = rdata_q;

    // Line data. The merged line is stored on entry to WRITE, so the buffer
    // already matches what is being written back.
    // NOTE: the 128-bit data store has no reset; the valid bit alone decides
    // whether its contents mean anything.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (request && hit && is_write)
                    line <= merge_line(line, word_idx, bus.mem_wdata, bus.mem_byte_enable);
            end
            FETCH: begin
                if (bus.pmem_resp)
                    line <= is_write
                          ? merge_line(bus.pmem_rdata, word_idx, bus.mem_wdata, bus.mem_byte_enable)
                          : bus.pmem_rdata;
            end
            default: ;
        endcase
    end

    // Read word register: loaded on the transition into DONE for reads and
    // held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (request && hit && !is_write)
                        rdata_q <= select_word(line, word_idx);
                end
                FETCH: begin
                    if (bus.pmem_resp && !is_write)
                        rdata_q <= select_word(bus.pmem_rdata, word_idx);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_line_bridge.sv
// Self-checking bench for mem_line_bridge: a table of CPU accesses with
// hand-computed results, a physical-memory responder with programmable
// latency, and hand-written reset sequences.
module tb_mem_line_bridge;
`ifdef MEM_LINE_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    localparam logic [127:0] L1000   = {16'hCAFE, 16'h1106, 16'h1105, 16'h1104,
                                        16'h1103, 16'hABCD, 16'hBEEF, 16'h1100};
    localparam logic [127:0] L1000_M = {16'hCAFE, 16'h1106, 16'h1105, 16'h1104,
                                        16'h1103, 16'hAB34, 16'hBEEF, 16'h1100};
    localparam logic [127:0] L2000_M = {16'h2207, 16'h2206, 16'h2205, 16'h2204,
                                        16'h2203, 16'h2202, 16'h2201, 16'h5A5A};
    localparam logic [127:0] L2000_N = {16'h2207, 16'h2206, 16'h2205, 16'h2204,
                                        16'h9903, 16'h2202, 16'h2201, 16'h5A5A};

    typedef struct {
        bit           rd;
        bit           wr;
        logic [15:0]  addr;
        logic [15:0]  wdata;
        logic [1:0]   be;
        int           lat;
        logic [15:0]  exp_rdata;
        int           exp_rd_on;
        int           exp_rd_off;
        int           exp_wr;
        logic [127:0] exp_line;
    } vec_t;

    logic clk;
    logic rst;
    mem_line_bridge_if bus();

    mem_line_bridge dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int           n_checks  = 0;
    int           n_pass    = 0;
    int           lat       = 1;
    int           n_reads   = 0;
    int           n_writes  = 0;
    int           proto_err = 0;
    int           cnt       = 0;
    bit           busy      = 1'b0;
    bit           inject_resp = 1'b0;
    logic [15:0]  last_read_addr  = 16'h0;
    logic [15:0]  last_write_addr = 16'h0;
    logic [15:0]  start_addr      = 16'h0;
    logic [127:0] last_write_data = 128'h0;
    logic [127:0] start_wdata     = 128'h0;
    logic [127:0] phys [logic [11:0]];

    always #5 clk = ~clk;

    function automatic logic [127:0] base_line(input logic [11:0] tag);
        logic [127:0] l;
        if (tag == 12'h100) return L1000;
        for (int k = 0; k < 8; k++)
            l[16*k +: 16] = {tag[11:8], tag[11:8], 8'h00} + 16'(k);
        return l;
    endfunction

    task automatic check(input string name, input logic [127:0] actual,
                         input logic [127:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    // Physical memory: answers each burst after 'lat' cycles, tracks
    // bursts and watches address/data stability and read/write exclusion.
    always @(negedge clk) begin
        if (rst) begin
            busy           = 1'b0;
            bus.pmem_resp  = 1'b0;
            bus.pmem_rdata = 128'h0;
        end else begin
            bus.pmem_resp = inject_resp;
            if (bus.pmem_read && bus.pmem_write) proto_err++;
            if (bus.pmem_read || bus.pmem_write) begin
                if (!busy) begin
                    busy        = 1'b1;
                    cnt         = 0;
                    start_addr  = bus.pmem_address;
                    start_wdata = bus.pmem_wdata;
                    if (bus.pmem_read) begin
                        n_reads++;
                        last_read_addr = bus.pmem_address;
                    end else begin
                        n_writes++;
                        last_write_addr = bus.pmem_address;
                        last_write_data = bus.pmem_wdata;
                    end
                end else if (bus.pmem_address != start_addr ||
                             (bus.pmem_write && bus.pmem_wdata != start_wdata)) begin
                    proto_err++;
                end
                cnt++;
                if (cnt >= lat) begin
                    bus.pmem_resp = 1'b1;
                    if (bus.pmem_read)
                        bus.pmem_rdata = phys.exists(bus.pmem_address[15:4])
                                       ? phys[bus.pmem_address[15:4]]
                                       : base_line(bus.pmem_address[15:4]);
                    else
                        phys[bus.pmem_address[15:4]] = bus.pmem_wdata;
                    busy = 1'b0;
                end
            end
        end
    end

    task automatic do_access(input vec_t v, output logic [15:0] rdata,
                             output int cycles, output bit timed_out,
                             output logic resp_after, output logic [15:0] rdata_after);
        lat                 = v.lat;
        bus.mem_read        = v.rd;
        bus.mem_write       = v.wr;
        bus.mem_address     = v.addr;
        bus.mem_wdata       = v.wdata;
        bus.mem_byte_enable = v.be;
        cycles    = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.mem_resp) begin
                timed_out = 1'b0;
                break;
            end
        end
        rdata         = bus.mem_rdata;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        @(negedge clk);
        resp_after  = bus.mem_resp;
        rdata_after = bus.mem_rdata;
    endtask

    vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rdata, rdata_after;
        logic        resp_after;
        int          cycles, rd0, wr0, exp_rd, resp_seen, read_seen;
        bit          timed_out;

        //          rd    wr    addr      wdata     be     lat rdata    on off wr line
        vecs[0] = '{1'b1, 1'b0, 16'h1002, 16'h0000, 2'b00, 3, 16'hBEEF, 1, 1, 0, 128'h0};
        vecs[1] = '{1'b1, 1'b0, 16'h100E, 16'h0000, 2'b00, 2, 16'hCAFE, 0, 1, 0, 128'h0};
        vecs[2] = '{1'b0, 1'b1, 16'h1004, 16'h1234, 2'b01, 2, 16'h0000, 0, 1, 1, L1000_M};
        vecs[3] = '{1'b1, 1'b0, 16'h1004, 16'h0000, 2'b00, 1, 16'hAB34, 0, 1, 0, 128'h0};
        vecs[4] = '{1'b0, 1'b1, 16'h2000, 16'h5A5A, 2'b11, 2, 16'h0000, 1, 1, 1, L2000_M};
        vecs[5] = '{1'b1, 1'b0, 16'h2000, 16'h0000, 2'b00, 1, 16'h5A5A, 0, 1, 0, 128'h0};
        vecs[6] = '{1'b0, 1'b1, 16'h2002, 16'hFFFF, 2'b00, 1, 16'h0000, 0, 1, 1, L2000_M};
        vecs[7] = '{1'b1, 1'b1, 16'h2006, 16'h9900, 2'b10, 2, 16'h0000, 0, 1, 1, L2000_N};
        vecs[8] = '{1'b1, 1'b0, 16'h2006, 16'h0000, 2'b00, 1, 16'h9903, 0, 1, 0, 128'h0};
        vecs[9] = '{1'b1, 1'b0, 16'h1003, 16'h0000, 2'b00, 2, 16'hBEEF, 1, 1, 0, 128'h0};

        clk = 1'b0;
        rst = 1'b1;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_address     = 16'h0;
        bus.mem_wdata       = 16'h0;
        bus.mem_byte_enable = 2'b00;

        repeat (2) @(negedge clk);
        check("reset_mem_resp",   bus.mem_resp,   1'b0);
        check("reset_pmem_read",  bus.pmem_read,  1'b0);
        check("reset_pmem_write", bus.pmem_write, 1'b0);
        check("reset_mem_rdata",  bus.mem_rdata,  16'h0000);
        #1 rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            rd0 = n_reads;
            wr0 = n_writes;
            exp_rd = BUF_EN ? vecs[i].exp_rd_on : vecs[i].exp_rd_off;
            do_access(vecs[i], rdata, cycles, timed_out, resp_after, rdata_after);
            check($sformatf("v%0d_timeout", i), timed_out, 1'b0);
            check($sformatf("v%0d_cycles", i), cycles,
                  1 + vecs[i].lat * (exp_rd + vecs[i].exp_wr));
            check($sformatf("v%0d_pmem_reads", i), n_reads - rd0, exp_rd);
            check($sformatf("v%0d_pmem_writes", i), n_writes - wr0, vecs[i].exp_wr);
            check($sformatf("v%0d_resp_one_cycle", i), resp_after, 1'b0);
            if (vecs[i].rd && !vecs[i].wr) begin
                check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
                check($sformatf("v%0d_rdata_hold", i), rdata_after, vecs[i].exp_rdata);
            end
            if (exp_rd > 0)
                check($sformatf("v%0d_read_addr", i), last_read_addr,
                      {vecs[i].addr[15:4], 4'h0});
            if (vecs[i].exp_wr > 0) begin
                check($sformatf("v%0d_write_addr", i), last_write_addr,
                      {vecs[i].addr[15:4], 4'h0});
                check($sformatf("v%0d_write_line", i), last_write_data, vecs[i].exp_line);
            end
        end

        // Reset in the middle of a fetch, then a stray pmem_resp.
        lat                 = 50;
        bus.mem_read        = 1'b1;
        bus.mem_address     = 16'h2004;
        bus.mem_byte_enable = 2'b00;
        repeat (2) @(negedge clk);
        check("abort_fetch_active", bus.pmem_read, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("abort_pmem_read",  bus.pmem_read,  1'b0);
        check("abort_pmem_write", bus.pmem_write, 1'b0);
        check("abort_mem_resp",   bus.mem_resp,   1'b0);
        check("abort_mem_rdata",  bus.mem_rdata,  16'h0000);
        bus.mem_read = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        rd0 = n_reads;
        @(posedge clk);
        #1 inject_resp = 1'b1;
        @(posedge clk);
        #1 inject_resp = 1'b0;
        resp_seen = 0;
        read_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.mem_resp)  resp_seen++;
            if (bus.pmem_read) read_seen++;
        end
        check("abort_no_mem_resp",  resp_seen, 0);
        check("abort_no_pmem_read", read_seen, 0);
        check("abort_no_new_burst", n_reads - rd0, 0);

        // Same address again must refetch since the buffer was invalidated.
        vecs[0] = '{1'b1, 1'b0, 16'h2004, 16'h0000, 2'b00, 2, 16'h2202, 1, 1, 0, 128'h0};
        rd0 = n_reads;
        do_access(vecs[0], rdata, cycles, timed_out, resp_after, rdata_after);
        check("refetch_timeout", timed_out, 1'b0);
        check("refetch_reads",   n_reads - rd0, 1);
        check("refetch_addr",    last_read_addr, 16'h2000);
        check("refetch_rdata",   rdata, 16'h2202);
        check("refetch_cycles",  cycles, 3);

        check("pmem_protocol_errors", proto_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_line_bridge.md
MEM_LINE_BRIDGE -- requirements
Module: mem_line_bridge

Interface
REQ-001 The block SHALL have no parameters; the line is fixed at 8 words x 16 bits = 128 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 mem_read  input  1  CPU word read request, held until mem_resp.
REQ-005 mem_write  input  1  CPU word write request, held until mem_resp.
REQ-006 mem_byte_enable  input  2  bit0 = byte [7:0], bit1 = byte [15:8].
REQ-007 mem_address  input  16  CPU byte address; bit 0 ignored.
REQ-008 mem_wdata  input  16  CPU write data.
REQ-009 mem_resp  output  1  one-cycle completion strobe to CPU.
REQ-010 mem_rdata  output  16  read word, valid while mem_resp = 1.
REQ-011 pmem_read  output  1  line read request to physical memory.
REQ-012 pmem_write  output  1  line write request to physical memory.
REQ-013 pmem_address  output  16  line address {mem_address[15:4], 4'b0}.
REQ-014 pmem_wdata  output  128  line write data; word k at bits [16k+15:16k].
REQ-015 pmem_rdata  input  128  line read data, valid with pmem_resp.
REQ-016 pmem_resp  input  1  physical transaction complete, variable latency of 1 or more cycles.

Function
REQ-017 The block SHALL hold a one-line buffer: valid bit, 12-bit tag (address[15:4]), and 128-bit data.
REQ-018 Hit SHALL mean valid = 1 and tag = mem_address[15:4]; the word index SHALL be mem_address[3:1].
REQ-019 FSM states SHALL be IDLE, FETCH, WRITE, DONE.
- IDLE: read hit -> DONE; write hit -> WRITE; any miss -> FETCH; no request -> IDLE.
- FETCH: pmem_read = 1 until pmem_resp; on pmem_resp, load line, tag, and valid = 1, then -> DONE if read, -> WRITE if write.
- WRITE: pmem_write = 1 with the merged line until pmem_resp, then -> DONE.
- DONE: mem_resp = 1 for exactly one cycle, then -> IDLE.
REQ-020 Write merge SHALL replace only the enabled bytes of the selected word; the buffer SHALL hold the merged line on entry to WRITE, so it stays coherent.
REQ-021 A write with mem_byte_enable = 2'b00 SHALL still write the unchanged line and complete with mem_resp.
REQ-022 Read-hit latency SHALL be 2 cycles from request (request in cycle 0, mem_resp in cycle 1).
REQ-023 Miss latency SHALL be the physical latency plus 2 cycles; a write miss SHALL add one physical write.
REQ-024 mem_rdata SHALL be registered and SHALL hold its last value outside DONE.
REQ-025 pmem_read and pmem_write SHALL never be asserted in the same cycle.
REQ-026 pmem_address and pmem_wdata SHALL stay stable while pmem_read or pmem_write is asserted.
REQ-027 pmem_resp SHALL be ignored in IDLE and DONE.
REQ-028 mem_read and mem_write asserted together is illegal; the block SHALL treat it as a write.
REQ-029 The CPU SHALL hold its address, data, and request until mem_resp; the block SHALL sample inputs only in IDLE and while in FETCH or WRITE.

Reset
REQ-030 On rst = 1 the block SHALL force IDLE, valid = 0, mem_resp = 0, pmem_read = 0, pmem_write = 0, and mem_rdata = 16'h0000, regardless of clk.
REQ-031 Reset in FETCH or WRITE SHALL abandon the physical transaction; any later pmem_resp SHALL be ignored.

Configuration
REQ-032 Macro MEM_LINE_BUF_EN defined: the line buffer operates as in REQ-017 to REQ-020.
REQ-033 Macro MEM_LINE_BUF_EN undefined: hit SHALL be forced to 0, so every read fetches the line and every write fetches then writes; the interface SHALL be unchanged.

Verification
REQ-034 Reset, then read 0x1002 with pmem_rdata word1 = 0xBEEF, pmem latency 3 -> exactly one pmem_read burst at 0x1000, then mem_resp with mem_rdata = 0xBEEF.
REQ-035 Read 0x100E immediately after REQ-034 -> no pmem activity; mem_resp in cycle 1 with word7 of the line.
REQ-036 Write 0x1004, data 0x1234, enable 2'b01, to the buffered line -> pmem_write at 0x1000 with word2 low byte = 0x34 and high byte unchanged; a following read of 0x1004 hits and returns the merged value.
REQ-037 Write miss to 0x2000 -> pmem_read at 0x2000, then pmem_write with the merged line, then a single mem_resp.
REQ-038 Assert rst during FETCH, then pulse pmem_resp -> all outputs 0 and no mem_resp; the next read of the same address refetches.
REQ-039 Build without MEM_LINE_BUF_EN and read 0x1002 twice -> two pmem_read bursts and identical data.
